// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default width for the shift-add multiplier
//
// Purpose : holds the 3-bit FSM state encoding and the default operand width
//           used by shift_add_multiplier and shift_add_datapath.
// Ports   : none (package).

package mult_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_WAIT = 3'd1,
        S_ADD       = 3'd2,
        S_SHIFT     = 3'd3,
        S_DONE      = 3'd4
    } mult_state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - operand, accumulator, counter and product registers
//
// Purpose : register file and arithmetic of the shift-add multiplier; it is
//           sequenced entirely by the load/add/shift/out strobes from the FSM.
// Ports   : clk, resetp          - clock, asynchronous active-high reset
//           load                - capture operands, clear A and the counter
//           add                 - A += {0,M} when Q[0] is set
//           shift               - {A,Q} >>= 1, counter += 1
//           out                 - product <= {A[N-1:0],Q}
//           multiplicand_in     - operand M (N bits)
//           multiplier_in       - operand Q (N bits)
//           last_iter           - the shift in progress is the N-th one
//           product             - last completed product (2N bits)

module shift_add_datapath #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           resetp,
    input  logic           load,
    input  logic           add,
    input  logic           shift,
    input  logic           out,
    input  logic [N-1:0]   multiplicand_in,
    input  logic [N-1:0]   multiplier_in,
    output logic           last_iter,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  m_reg;
    logic [N:0]    a_reg;
    logic [N-1:0]  q_reg;
    logic [CW-1:0] cnt;

    // Counter still holds the pre-increment value during S_SHIFT.
    assign last_iter = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge resetp) begin
        if (resetp) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                m_reg <= multiplicand_in;
                q_reg <= multiplier_in;
                a_reg <= '0;
                cnt   <= '0;
            end
            if (add && q_reg[0]) begin
                // A carries one spare bit so the sum never overflows.
                a_reg <= a_reg + {1'b0, m_reg};
            end
            if (shift) begin
                a_reg <= {1'b0, a_reg[N:1]};
                q_reg <= {a_reg[0], q_reg[N-1:1]};
                cnt   <= cnt + CW'(1);
            end
            if (out) begin
                product <= {a_reg[N-1:0], q_reg};
            end
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-add multiplier (top, FSM)
//
// Purpose : multiplies two unsigned N-bit operands in a fixed 2N+1 cycles after
//           go is released, using one add and one shift step per multiplier bit.
// Ports   : clk               - clock, rising edge
//           resetp            - asynchronous active-high reset
//           go                - start request (press-and-release)
//           multiplicand_in   - operand M (N bits)
//           multiplier_in     - operand Q (N bits)
//           busy              - high whenever the FSM is not idle
//           done              - one-cycle pulse when product becomes valid
//           product           - last completed M*Q (2N bits)

module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           resetp,
    input  logic           go,
    input  logic [N-1:0]   multiplicand_in,
    input  logic [N-1:0]   multiplier_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    mult_state_t state;
    logic        last_iter;
    logic        load;
    logic        add;
    logic        shift;
    logic        out;

    assign load  = (state == S_LOAD_WAIT);
    assign add   = (state == S_ADD);
    assign shift = (state == S_SHIFT);
    assign out   = (state == S_DONE);

    // busy tracks the state being entered; done is asserted on the same edge
    // that loads product, so both become visible together.
    always_ff @(posedge clk or posedge resetp) begin
        if (resetp) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_LOAD_WAIT;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD_WAIT: begin
                    if (!go) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    state <= last_iter ? S_DONE : S_ADD;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    shift_add_datapath #(.N(N)) u_datapath (
        .clk             (clk),
        .resetp          (resetp),
        .load            (load),
        .add             (add),
        .shift           (shift),
        .out             (out),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .last_iter       (last_iter),
        .product         (product)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier (N=4)

module tb_shift_add_multiplier;

    localparam int N   = 4;
    localparam int LAT = 2 * N + 1;

    logic         clk = 1'b0;
    logic         resetp;
    logic         go;
    logic [N-1:0] m_in;
    logic [N-1:0] q_in;
    logic         busy;
    logic         done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] p;
        int             hold;
    } vec_t;

    vec_t vecs[7];

    shift_add_multiplier #(.N(N)) dut (
        .clk             (clk),
        .resetp          (resetp),
        .go              (go),
        .multiplicand_in (m_in),
        .multiplier_in   (q_in),
        .busy            (busy),
        .done            (done),
        .product         (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after the edge at which LOAD_WAIT samples go=0.
    task automatic start_op(input logic [N-1:0] m, input logic [N-1:0] q, input int hold);
        m_in = m;
        q_in = q;
        go   = 1'b1;
        repeat (hold) tick();
        go = 1'b0;
        tick();
        check("busy_after_release", 32'(busy), 32'd1);
    endtask

    // Counts edges until done is seen (0 on timeout); flags any product change before it.
    task automatic wait_done(output int lat, output bit stable);
        logic [2*N-1:0] p0;
        p0     = product;
        lat    = 0;
        stable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
            if (product !== p0) stable = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int pre;
        bit stable;
        bit seen;

        vecs[0] = '{m: 4'd13, q: 4'd11, p: 8'h8F, hold: 3};
        vecs[1] = '{m: 4'd15, q: 4'd15, p: 8'hE1, hold: 1};
        vecs[2] = '{m: 4'd0,  q: 4'd9,  p: 8'h00, hold: 2};
        vecs[3] = '{m: 4'd9,  q: 4'd0,  p: 8'h00, hold: 1};
        vecs[4] = '{m: 4'd1,  q: 4'd1,  p: 8'h01, hold: 1};
        vecs[5] = '{m: 4'd15, q: 4'd1,  p: 8'h0F, hold: 4};
        vecs[6] = '{m: 4'd8,  q: 4'd8,  p: 8'h40, hold: 1};

        resetp = 1'b1;
        go     = 1'b0;
        m_in   = '0;
        q_in   = '0;
        #1;
        check("reset_product", 32'(product), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        resetp = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            start_op(vecs[i].m, vecs[i].q, vecs[i].hold);
            wait_done(lat, stable);
            check("vec_latency", 32'(lat), 32'(LAT));
            check("vec_product", 32'(product), 32'(vecs[i].p));
            check("vec_product_stable", 32'(stable), 32'd1);
            check("vec_busy_at_done", 32'(busy), 32'd0);
            tick();
            check("vec_done_width", 32'(done), 32'd0);
            check("vec_busy_after", 32'(busy), 32'd0);
        end

        // Operands wiggle during load, final 6 and 7; wiggle again during compute
        m_in = 4'd3; q_in = 4'd2; go = 1'b1;
        tick();
        m_in = 4'd9; q_in = 4'd4;
        tick();
        m_in = 4'd6; q_in = 4'd7;
        tick();
        go = 1'b0;
        tick();
        pre = 0;
        for (int k = 0; k < 4; k++) begin
            m_in = 4'($urandom_range(0, 15));
            q_in = 4'($urandom_range(0, 15));
            tick();
            pre++;
            if (done) break;
        end
        wait_done(lat, stable);
        check("wiggle_latency", 32'(lat + pre), 32'(LAT));
        check("wiggle_product", 32'(product), 32'h2A);
        tick();

        // Reset during the third shift step
        start_op(4'd13, 4'd11, 1);
        repeat (5) tick();
        #2;
        resetp = 1'b1;
        #1;
        check("midreset_product", 32'(product), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        #2;
        resetp = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("midreset_no_done", 32'(seen), 32'd0);
        start_op(4'd5, 4'd3, 1);
        wait_done(lat, stable);
        check("postreset_latency", 32'(lat), 32'(LAT));
        check("postreset_product", 32'(product), 32'h0F);
        tick();

        // go held high during compute, then a back-to-back second operation
        m_in = 4'd3; q_in = 4'd5; go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        tick();
        go = 1'b1;
        wait_done(lat, stable);
        check("held_go_latency", 32'(lat), 32'(LAT));
        check("held_go_product1", 32'(product), 32'h0F);
        m_in = 4'd7; q_in = 4'd9;
        tick();
        check("held_go_restart_busy", 32'(busy), 32'd1);
        check("held_go_done_width", 32'(done), 32'd0);
        go = 1'b0;
        tick();
        wait_done(lat, stable);
        check("held_go_latency2", 32'(lat), 32'(LAT));
        check("held_go_product2", 32'(product), 32'h3F);
        tick();

        // Exhaustive sweep against m*q
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [2*N-1:0] ref_p;
                ref_p = 8'(a * b);
                start_op(4'(a), 4'(b), 1);
                wait_done(lat, stable);
                check("sweep_latency", 32'(lat), 32'(LAT));
                check("sweep_product", 32'(product), 32'(ref_p));
                tick();
                check("sweep_done_width", 32'(done), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
